// File: rtl/chunked_magnitude_comp.sv
// chunked_magnitude_comp
//   Multi-cycle magnitude comparator for WIDTH-bit operands. The operands are
//   captured on an input handshake. They are then compared CHUNK bits per
//   cycle, starting at the most significant chunk. The compare stops at the
//   first chunk that differs. Signed compares are turned into unsigned ones
//   by flipping the sign bit of both operands at capture.
//   The result is held until the output handshake. Saturating counters track
//   the number of accepted equal, less-than and greater-than results.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake; in_ready is high only when idle
//   input_a, input_b      operands (WIDTH bits)
//   signed_mode           1 = two's-complement compare, sampled at accept
//   out_valid / out_ready result handshake; result held until accepted
//   equal_to, less_than,  one-hot result flags (A==B, A<B, A>B)
//   greater_than
//   out_chunks            chunks examined for the current result (1..NCHUNK)
//   clr_cnt               synchronous clear of all result counters
//   cnt_eq, cnt_lt,       saturating counts of accepted results
//   cnt_gt
module chunked_magnitude_comp #(
    parameter int WIDTH  = 16,
    parameter int CHUNK  = 4,
    parameter int CNT_W  = 8,
    localparam int NCHUNK = WIDTH / CHUNK,
    localparam int CW     = $clog2(NCHUNK + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             equal_to,
    output logic             less_than,
    output logic             greater_than,
    output logic [CW-1:0]    out_chunks,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_eq,
    output logic [CNT_W-1:0] cnt_lt,
    output logic [CNT_W-1:0] cnt_gt
);

    localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NCHUNK - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [IDX_W-1:0]  idx_r;
    logic [WIDTH-1:0]  a_shift_s;
    logic [WIDTH-1:0]  b_shift_s;
    logic [CHUNK-1:0]  a_chunk_s;
    logic [CHUNK-1:0]  b_chunk_s;
    logic              accept_s;
    logic              handshake_s;
    logic              decide_s;
    logic              eq_s;
    logic              lt_s;
    logic              gt_s;
    logic [CW-1:0]     chunks_s;
    logic              eq_r;
    logic              lt_r;
    logic              gt_r;
    logic [CW-1:0]     chunks_r;
    logic              out_valid_r;
    logic              in_ready_r;
    logic [CNT_W-1:0]  cnt_eq_r;
    logic [CNT_W-1:0]  cnt_lt_r;
    logic [CNT_W-1:0]  cnt_gt_r;

    // The chunk under test is brought down to the bottom bits by a shift.
    assign a_shift_s   = a_r >> (idx_r * CHUNK);
    assign b_shift_s   = b_r >> (idx_r * CHUNK);
    assign a_chunk_s   = a_shift_s[CHUNK-1:0];
    assign b_chunk_s   = b_shift_s[CHUNK-1:0];
    assign accept_s    = in_valid && (state_r == ST_IDLE);
    assign handshake_s = out_valid_r && out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: leave CMP on the first differing chunk or after the last chunk.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_s = ST_CMP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CMP: begin
                if ((a_chunk_s != b_chunk_s) || (idx_r == IDX_ZERO)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CMP;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: the next flag values, which change only on the deciding CMP cycle.
    always_comb begin
        decide_s = 1'b0;
        eq_s     = eq_r;
        lt_s     = lt_r;
        gt_s     = gt_r;
        chunks_s = chunks_r;
        if ((state_r == ST_CMP) &&
            ((a_chunk_s != b_chunk_s) || (idx_r == IDX_ZERO))) begin
            decide_s = 1'b1;
            eq_s     = (a_chunk_s == b_chunk_s);
            lt_s     = (a_chunk_s <  b_chunk_s);
            gt_s     = (a_chunk_s >  b_chunk_s);
            chunks_s = CW'(NCHUNK) - CW'(idx_r);
        end else begin
            decide_s = 1'b0;
        end
    end

    // Operand capture and chunk index. In signed mode the sign bits are flipped,
    // which maps two's-complement order onto unsigned order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= {WIDTH{1'b0}};
            b_r   <= {WIDTH{1'b0}};
            idx_r <= IDX_ZERO;
        end else if (accept_s) begin
            a_r   <= {input_a[WIDTH-1] ^ signed_mode, input_a[WIDTH-2:0]};
            b_r   <= {input_b[WIDTH-1] ^ signed_mode, input_b[WIDTH-2:0]};
            idx_r <= IDX_TOP;
        end else if ((state_r == ST_CMP) && !decide_s) begin
            idx_r <= idx_r - IDX_W'(1);
        end else begin
            idx_r <= idx_r;
        end
    end

    // Result flags and chunk count. These hold after the handshake until the next decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_r     <= 1'b0;
            lt_r     <= 1'b0;
            gt_r     <= 1'b0;
            chunks_r <= {CW{1'b0}};
        end else begin
            eq_r     <= eq_s;
            lt_r     <= lt_s;
            gt_r     <= gt_s;
            chunks_r <= chunks_s;
        end
    end

    // Handshake outputs. These are registered copies of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            out_valid_r <= (state_s == ST_DONE);
            in_ready_r  <= (state_s == ST_IDLE);
        end
    end

    // Saturating result counters. A clear takes priority over a coinciding handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_eq_r <= CNT_ZERO;
            cnt_lt_r <= CNT_ZERO;
            cnt_gt_r <= CNT_ZERO;
        end else if (clr_cnt) begin
            cnt_eq_r <= CNT_ZERO;
            cnt_lt_r <= CNT_ZERO;
            cnt_gt_r <= CNT_ZERO;
        end else if (handshake_s) begin
            if (eq_r && (cnt_eq_r != CNT_MAX)) begin
                cnt_eq_r <= cnt_eq_r + CNT_W'(1);
            end else begin
                cnt_eq_r <= cnt_eq_r;
            end
            if (lt_r && (cnt_lt_r != CNT_MAX)) begin
                cnt_lt_r <= cnt_lt_r + CNT_W'(1);
            end else begin
                cnt_lt_r <= cnt_lt_r;
            end
            if (gt_r && (cnt_gt_r != CNT_MAX)) begin
                cnt_gt_r <= cnt_gt_r + CNT_W'(1);
            end else begin
                cnt_gt_r <= cnt_gt_r;
            end
        end else begin
            cnt_eq_r <= cnt_eq_r;
            cnt_lt_r <= cnt_lt_r;
            cnt_gt_r <= cnt_gt_r;
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign equal_to     = eq_r;
    assign less_than    = lt_r;
    assign greater_than = gt_r;
    assign out_chunks   = chunks_r;
    assign cnt_eq       = cnt_eq_r;
    assign cnt_lt       = cnt_lt_r;
    assign cnt_gt       = cnt_gt_r;

endmodule

// File: tb/tb_chunked_magnitude_comp.sv
// tb_chunked_magnitude_comp
//   Self-checking bench for chunked_magnitude_comp (WIDTH=16, CHUNK=4, CNT_W=4).
//   The expected results come from plain signed/unsigned arithmetic. The
//   expected chunk count comes from the position of the highest differing bit.
//   The bench also keeps its own saturating counters.
module tb_chunked_magnitude_comp;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int CNT_W  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  input_a;
    logic [WIDTH-1:0]  input_b;
    logic              signed_mode;
    logic              out_valid;
    logic              out_ready;
    logic              equal_to;
    logic              less_than;
    logic              greater_than;
    logic [2:0]        out_chunks;
    logic              clr_cnt;
    logic [CNT_W-1:0]  cnt_eq;
    logic [CNT_W-1:0]  cnt_lt;
    logic [CNT_W-1:0]  cnt_gt;

    int checks_s;
    int errors_s;
    int m_eq_s;
    int m_lt_s;
    int m_gt_s;

    chunked_magnitude_comp #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .input_a      (input_a),
        .input_b      (input_b),
        .signed_mode  (signed_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .equal_to     (equal_to),
        .less_than    (less_than),
        .greater_than (greater_than),
        .out_chunks   (out_chunks),
        .clr_cnt      (clr_cnt),
        .cnt_eq       (cnt_eq),
        .cnt_lt       (cnt_lt),
        .cnt_gt       (cnt_gt)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_s++;
        if (obs !== exp) begin
            errors_s++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Chunks examined = chunks down to and including the one holding the highest differing bit.
    function automatic int ref_chunks(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] d;
        d = a ^ b;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (d[i]) return NCHUNK - (i / CHUNK);
        end
        return NCHUNK;
    endfunction

    task automatic check_counters(input string tag);
        check_val({tag, "_cnt_eq"}, 32'(cnt_eq), 32'(m_eq_s));
        check_val({tag, "_cnt_lt"}, 32'(cnt_lt), 32'(m_lt_s));
        check_val({tag, "_cnt_gt"}, 32'(cnt_gt), 32'(m_gt_s));
    endtask

    // One full transaction. This task is entered and left at 1 time unit after a rising edge.
    task automatic do_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s, input int hold, input logic clr);
        logic e_eq;
        logic e_lt;
        logic e_gt;
        int   e_ch;
        int   lat;
        if (s) begin
            e_eq = ($signed(a) == $signed(b));
            e_lt = ($signed(a) <  $signed(b));
            e_gt = ($signed(a) >  $signed(b));
        end else begin
            e_eq = (a == b);
            e_lt = (a <  b);
            e_gt = (a >  b);
        end
        e_ch = ref_chunks(a, b);

        check_val("in_ready_idle", 32'(in_ready), 32'd1);
        input_a     = a;
        input_b     = b;
        signed_mode = s;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        input_a     = WIDTH'($urandom);
        input_b     = WIDTH'($urandom);
        signed_mode = 1'($urandom);

        lat = 0;
        while (!out_valid && lat < 3 * NCHUNK) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("latency", 32'(lat), 32'(e_ch));
        check_val("equal_to", 32'(equal_to), 32'(e_eq));
        check_val("less_than", 32'(less_than), 32'(e_lt));
        check_val("greater_than", 32'(greater_than), 32'(e_gt));
        check_val("out_chunks", 32'(out_chunks), 32'(e_ch));
        check_val("in_ready_busy", 32'(in_ready), 32'd0);

        // Backpressure: the result must hold. An in_valid pulse here must be ignored.
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                input_a  = WIDTH'($urandom);
                input_b  = WIDTH'($urandom);
                in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            check_val("hold_out_valid", 32'(out_valid), 32'd1);
            check_val("hold_in_ready", 32'(in_ready), 32'd0);
            check_val("hold_flags", {29'd0, equal_to, less_than, greater_than},
                      {29'd0, e_eq, e_lt, e_gt});
            check_val("hold_chunks", 32'(out_chunks), 32'(e_ch));
        end

        out_ready = 1'b1;
        clr_cnt   = clr;
        @(posedge clk); #1;
        out_ready = 1'b0;
        clr_cnt   = 1'b0;
        if (clr) begin
            m_eq_s = 0;
            m_lt_s = 0;
            m_gt_s = 0;
        end else begin
            if (e_eq && m_eq_s < CNT_SAT) m_eq_s++;
            if (e_lt && m_lt_s < CNT_SAT) m_lt_s++;
            if (e_gt && m_gt_s < CNT_SAT) m_gt_s++;
        end
        check_val("post_out_valid", 32'(out_valid), 32'd0);
        check_val("post_in_ready", 32'(in_ready), 32'd1);
        check_val("post_flags_hold", {29'd0, equal_to, less_than, greater_than},
                  {29'd0, e_eq, e_lt, e_gt});
        check_val("post_chunks_hold", 32'(out_chunks), 32'(e_ch));
        check_counters("post");
    endtask

    // Main stimulus sequence.
    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        checks_s    = 0;
        errors_s    = 0;
        m_eq_s      = 0;
        m_lt_s      = 0;
        m_gt_s      = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        input_a     = 16'h0000;
        input_b     = 16'h0000;
        signed_mode = 1'b0;
        out_ready   = 1'b0;
        clr_cnt     = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_flags", {29'd0, equal_to, less_than, greater_than}, 32'd0);
        check_val("rst_chunks", 32'(out_chunks), 32'd0);
        check_counters("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("rel_in_ready", 32'(in_ready), 32'd1);

        // Directed cases.
        do_txn(16'h1234, 16'h1234, 1'b0, 0, 1'b0);
        do_txn(16'h8000, 16'h7FFF, 1'b0, 0, 1'b0);
        do_txn(16'h8000, 16'h7FFF, 1'b1, 0, 1'b0);
        do_txn(16'hFFFF, 16'hFFFE, 1'b1, 0, 1'b0);
        do_txn(16'h12F0, 16'h12E0, 1'b0, 0, 1'b0);
        do_txn(16'h1234, 16'h1235, 1'b0, 5, 1'b0);

        // Saturation: clear on an equal handshake, then 17 greater-than results, then clear again.
        do_txn(16'h5555, 16'h5555, 1'b0, 0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            ra = WIDTH'($urandom_range(1, 65535));
            rb = WIDTH'($urandom_range(0, int'(ra) - 1));
            do_txn(ra, rb, 1'b0, 0, 1'b0);
        end
        check_val("sat_cnt_gt", 32'(cnt_gt), 32'd15);
        do_txn(16'hABCD, 16'hABCD, 1'b1, 1, 1'b1);

        // Random transactions. Some operands share their upper chunks to vary out_chunks.
        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = {ra[15:8], rb[7:0]};
                2: rb = {ra[15:4], rb[3:0]};
                default: rb = rb;
            endcase
            do_txn(ra, rb, 1'($urandom), $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
        end

        // Reset during CMP after two chunks have been examined.
        input_a     = 16'h1234;
        input_b     = 16'h1235;
        signed_mode = 1'b0;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("midcmp_busy", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        m_eq_s = 0;
        m_lt_s = 0;
        m_gt_s = 0;
        check_val("midrst_in_ready", 32'(in_ready), 32'd1);
        check_val("midrst_out_valid", 32'(out_valid), 32'd0);
        check_val("midrst_flags", {29'd0, equal_to, less_than, greater_than}, 32'd0);
        check_val("midrst_chunks", 32'(out_chunks), 32'd0);
        check_counters("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_txn(16'h0001, 16'h0000, 1'b0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks_s, errors_s);
        $finish;
    end

endmodule

// File: doc/chunked_magnitude_comp.md
Name: chunked_magnitude_comp

Overview:
- Multi-cycle, parametrised magnitude comparator for WIDTH-bit operands, signed or unsigned per transaction.
- Compares CHUNK bits per cycle, MSB chunk first, and stops at the first differing chunk.
- Uses a valid/ready handshake on both input and output, and keeps saturating result counters.
- Successor to the 4-bit combinational comparator, for wide datapaths where a full-width compare in one cycle is too slow.

Parameters:
- WIDTH, 16: operand width; must be an integer multiple of CHUNK.
- CHUNK, 4: bits compared per cycle; NCHUNK = WIDTH/CHUNK.
- CNT_W, 8: width of each saturating result counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- input_a  input  WIDTH  operand A.
- input_b  input  WIDTH  operand B.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled at accept.
- out_valid  output  1  result flags are valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- equal_to  output  1  A == B.
- less_than  output  1  A < B.
- greater_than  output  1  A > B.
- out_chunks  output  $clog2(NCHUNK+1)  number of chunks examined for this result (1..NCHUNK).
- clr_cnt  input  1  synchronous clear of all counters.
- cnt_eq  output  CNT_W  saturating count of accepted equal results.
- cnt_lt  output  CNT_W  saturating count of accepted less-than results.
- cnt_gt  output  CNT_W  saturating count of accepted greater-than results.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all registered outputs, counters, flags, out_chunks and out_valid = 0.
  - in_ready = 1, both during reset and after release.
  - Reset asserted mid-compare or mid-DONE aborts the transaction; nothing is counted.
- FSM states: IDLE, CMP, DONE. in_ready = (state==IDLE). out_valid = (state==DONE), registered.
- IDLE:
  - On in_valid && in_ready at an edge: capture A and B, set idx = NCHUNK-1, go to CMP.
  - In signed mode, invert the MSB of both captured operands so the compare below is a plain unsigned compare.
- CMP, one chunk per cycle, slice [idx*CHUNK +: CHUNK]:
  - A chunk > B chunk: set greater_than, go to DONE.
  - A chunk < B chunk: set less_than, go to DONE.
  - Chunks equal and idx==0: set equal_to, go to DONE.
  - Otherwise decrement idx and stay in CMP.
  - out_chunks = NCHUNK - idx at the deciding cycle.
- Latency: with the accept edge at cycle k, out_valid rises at edge k+m, where m = out_chunks (1..NCHUNK).
- Exactly one result flag is high whenever out_valid=1.
- DONE:
  - Flags and out_chunks stay stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE and increment the matching counter.
  - Flags and out_chunks hold their last value after the handshake, until the next decision.
- Back-to-back: minimum one IDLE cycle between transactions, so the next accept can occur the edge after the output handshake.
- in_valid outside IDLE is ignored; no queuing.
- Counters saturate at 2^CNT_W-1 with no wrap.
- clr_cnt zeroes all counters at the next edge. If clr_cnt coincides with an output handshake, the clear wins and all counters read 0.
- Input operands and signed_mode may change freely after accept; the captured copies are used.

Test Plan:
- WIDTH=16, CHUNK=4, unsigned, A=0x1234, B=0x1234 -> equal_to=1, out_chunks=4, out_valid rises 4 edges after accept, cnt_eq=1.
- A=0x8000, B=0x7FFF -> unsigned: greater_than=1, out_chunks=1. Signed: less_than=1, out_chunks=1. Also signed A=0xFFFF(-1) vs B=0xFFFE(-2) -> greater_than=1, out_chunks=4.
- Early exit and last-chunk cases:
  - A=0x12F0, B=0x12E0 -> greater_than=1, out_chunks=3.
  - A=0x1234, B=0x1235 -> less_than=1, out_chunks=4.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid=1, flags and out_chunks unchanged, in_ready=0.
  - Pulse in_valid with new operands during that window -> ignored.
  - Release out_ready -> in_ready=1 on the next cycle.
- Counters with CNT_W=4:
  - 17 accepted greater-than results -> cnt_gt=15, cnt_lt=cnt_eq=0.
  - Assert clr_cnt on the same edge as an equal handshake -> all counters = 0.
- Reset mid-CMP (A=0x1234, B=0x1235, rst_n low after 2 chunks):
  - All outputs and counters read 0 immediately; in_ready=1.
  - After release, a fresh compare A=0x0001, B=0x0000 -> greater_than=1, out_chunks=4.
